// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - MEM-stage data memory with byte/half/word access and fixed wait states
// Little-endian lanes; stall is held while an access counts down its wait states.
module mem_stage_dmem #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_half, is_word, mis_c, req;
  logic          complete, stall_c, wr_en;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes, rword, rdata_c;
  logic [15:0]   rhalf;
  logic [7:0]    rbyte;
  logic          unused_addr_bits;

  assign idx              = address[AW+1:2];
  assign lane             = address[1:0];
  assign unused_addr_bits = ^address[31:AW+2];

  assign is_half = (MemSize == 2'b01);
  assign is_word = MemSize[1];
  assign mis_c   = (MemRead | MemWrite) & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
  assign req     = (MemRead | MemWrite) & ~mis_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        // Request vanishing mid-access means the pipeline flushed it.
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = writedata;
    case (MemSize)
      2'b00: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{writedata[7:0]}};
      end
      2'b01: begin
        byte_en     = 4'b0011 << lane;
        wdata_lanes = {2{writedata[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        wdata_lanes = writedata;
      end
    endcase
  end

  assign wr_en = complete & MemWrite & rst_n;

  // Array has no reset; contents are only defined once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem_q[idx][8*k +: 8] <= wdata_lanes[8*k +: 8];
      end
    end
  end

  assign rword = mem_q[idx];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];
  assign rbyte = lane[0] ? rhalf[15:8] : rhalf[7:0];

  always_comb begin
    rdata_c = rword;
    case (MemSize)
      2'b00:   rdata_c = {{24{MemSigned & rbyte[7]}}, rbyte};
      2'b01:   rdata_c = {{16{MemSigned & rhalf[15]}}, rhalf};
      default: rdata_c = rword;
    endcase
  end

  assign readdata   = (rst_n & complete & MemRead & ~MemWrite) ? rdata_c : 32'd0;
  assign stall      = rst_n & stall_c;
  assign misaligned = rst_n & mis_c;

endmodule
